// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_unit
// Brief   : Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_count;
  logic [WIDTH:0]    r_rem;
  logic [WIDTH-1:0]  r_quot;
  logic [WIDTH-1:0]  r_divisor;
  logic              r_negQuot;
  logic              r_negRem;
  logic              r_divZero;
  logic              r_done;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;

  logic              w_accept;
  logic              w_lastIter;
  logic [WIDTH:0]    w_shifted;
  logic [WIDTH:0]    w_diff;
  logic [WIDTH:0]    w_remNext;
  logic [WIDTH-1:0]  w_quotNext;
  logic [WIDTH-1:0]  w_hiRes;
  logic [WIDTH-1:0]  w_loRes;
  logic [WIDTH-1:0]  w_absA;
  logic [WIDTH-1:0]  w_absB;

  assign w_accept   = (r_state == IDLE) && start && !flush;
  assign w_lastIter = (r_state == CALC) && (r_count == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = CALC;
          busy        = 1'b1;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (w_lastIter) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (flush) w_nextState = IDLE;
  end

  // Magnitudes; the most negative value maps to unsigned 2^(WIDTH-1).
  assign w_absA = (signed_div && a[WIDTH-1]) ? -a : a;
  assign w_absB = (signed_div && b[WIDTH-1]) ? -b : b;

  assign w_shifted  = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
  assign w_diff     = w_shifted - {1'b0, r_divisor};
  assign w_remNext  = w_diff[WIDTH] ? w_shifted : w_diff;
  assign w_quotNext = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

  // After a divide by zero the remainder equals |a|; restoring a's sign gives raw a.
  assign w_loRes = r_divZero ? {WIDTH{1'b1}} :
                   (r_negQuot ? -w_quotNext : w_quotNext);
  assign w_hiRes = r_negRem ? -w_remNext[WIDTH-1:0] : w_remNext[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_negQuot <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= (w_nextState == DONE);
      if (w_accept) begin
        r_count   <= CNT_W'(WIDTH);
        r_rem     <= '0;
        r_quot    <= w_absA;
        r_divisor <= w_absB;
        r_divZero <= (b == '0);
        r_negQuot <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_negRem  <= signed_div && a[WIDTH-1];
      end else if (r_state == CALC && !flush) begin
        r_count <= r_count - CNT_W'(1);
        r_rem   <= w_remNext;
        r_quot  <= w_quotNext;
        if (w_lastIter) begin
          r_hi <= w_hiRes;
          r_lo <= w_loRes;
        end
      end
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// Directed bench for div_unit: scoreboard of expected {hi,lo} popped on done.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sbq[$];
  int   nTests = 0;
  int   nFail  = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation at a negedge and waits (bounded) for its done pulse.
  task automatic runOp(input string tag, input logic sgn, input logic [31:0] opA,
                       input logic [31:0] opB, input logic [31:0] expHi,
                       input logic [31:0] expLo, input bit holdStart);
    res_t r;
    int   cyc;
    bit   seen;
    bit   busyOk;
    r.hi = expHi;
    r.lo = expLo;
    sbq.push_back(r);
    a = opA; b = opB; signed_div = sgn; start = 1'b1;
    #1;
    busyOk = (busy === 1'b1);
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busyOk = 0;
      start = holdStart && !seen;
      if (start) begin
        a = $urandom; b = $urandom; signed_div = 1'($urandom);
      end
    end
    check({tag, "_latency"}, 64'(cyc), 64'd33);
    check({tag, "_busy_until_done"}, 64'(busyOk), 64'd1);
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    if (sbq.size() != 0) r = sbq.pop_front();
    if (seen) begin
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, r.hi});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, r.lo});
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  task automatic watchIdle(input string tag, input int n);
    int dn = 0;
    int bz = 0;
    repeat (n) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
      if (busy !== 1'b0) bz++;
    end
    check({tag, "_no_done"}, 64'(dn), 64'd0);
    check({tag, "_no_busy"}, 64'(bz), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; flush = 1'b0;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    runOp("divu_100_7",   1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         0);
    runOp("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   0);
    runOp("div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   0);
    runOp("divu_5_0",     1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   0);
    runOp("div_m20_0",    1'b1, 32'hFFFFFFEC,   32'd0,          32'hFFFFFFEC,   32'hFFFFFFFF,   0);
    runOp("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   0);
    runOp("divu_fff9_2",  1'b0, 32'hFFFFFFF9,   32'd2,          32'd1,          32'h7FFFFFFC,   0);
    runOp("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   0);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = 32'($urandom_range(1, 65535));
      runOp("divu_rand", 1'b0, ra, rb, ra % rb, ra / rb, 0);
    end

    // start held high with changing operands: only the first op is taken.
    runOp("hold_start", 1'b0, 32'd1000, 32'd10, 32'd0, 32'd100, 1);
    watchIdle("hold_after", 40);

    // Flush in CALC cycle 10.
    a = 32'd12345; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_next", {63'd0, busy}, 64'd0);
    check("flush_hi_kept", {32'd0, hi}, 64'd0);
    check("flush_lo_kept", {32'd0, lo}, 64'd100);
    start = 1'b1; flush = 1'b1;
    #1;
    check("flush_prio_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    watchIdle("flush_after", 40);
    runOp("div_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 0);

    // Asynchronous reset between edges mid-CALC.
    a = 32'd77; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    #1;
    rst = 1'b0;
    watchIdle("arst_after", 40);
    runOp("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
